// File: rtl/multicycle_controlpath.sv
// multicycle_controlpath: RV32I multicycle control FSM with memory wait-state
// handshake, six branch conditions from ALU flags, JAL and JALR sequencing.
// Params : MEM_WAIT   minimum extra cycles in FETCH/MEMREAD/MEMWRITE
// Inputs : clk, rst (async, active high), Instr, Zero/Neg/Carry/Ovf flags,
//          mem_ready (memory completion handshake)
// Outputs: PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc strobes/select,
//          ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALU_Control selects,
//          instr_done (last cycle of an instruction), illegal (trap state)
// Macro  : RV_UPPER_EN enables LUI/AUIPC via the UPPER state.
module multicycle_controlpath #(
  parameter int MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        Neg,
  input  logic        Carry,
  input  logic        Ovf,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ImmSrc,
  output logic [3:0]  ALU_Control,
  output logic        instr_done,
  output logic        illegal
);

  localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LINK,
`ifdef RV_UPPER_EN
    S_UPPER,
`endif
    S_ILLEGAL
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [6:0] op;
  logic [2:0] f3;
  logic       mem_done;
  logic       br_ok, br_tk;
  logic [3:0] alu_dec;
  state_t     disp;
  logic       pcw, irw, rw, mw;
  logic       done_raw, ill_raw;
  logic       unused_instr;

  assign op = Instr[6:0];
  assign f3 = Instr[14:12];
  assign unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};

  // Memory completion: counter drained and memory reports ready.
  assign mem_done = (cnt_q == '0) && mem_ready;

  // Immediate format follows the opcode in every state.
  always_comb begin
    ImmSrc = IMM_I;
    unique case (1'b1)
      (op == OP_STORE): ImmSrc = IMM_S;
      (op == OP_BR):    ImmSrc = IMM_B;
      (op == OP_JAL):   ImmSrc = IMM_J;
`ifdef RV_UPPER_EN
      (op == OP_LUI),
      (op == OP_AUIPC): ImmSrc = IMM_U;
`endif
      default:          ImmSrc = IMM_I;
    endcase
  end

  // Only R-type can select SUB through bit 30; addi ignores it.
  always_comb begin
    case (f3)
      3'b000: alu_dec = (state_q == S_EXECR && Instr[30]) ? ALU_SUB : ALU_ADD;
      3'b001: alu_dec = ALU_SLL;
      3'b010: alu_dec = ALU_SLT;
      3'b011: alu_dec = ALU_SLTU;
      3'b100: alu_dec = ALU_XOR;
      3'b101: alu_dec = Instr[30] ? ALU_SRA : ALU_SRL;
      3'b110: alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  end

  // Flags come from rs1 - rs2 in the BRANCH cycle itself.
  always_comb begin
    br_ok = 1'b1;
    br_tk = 1'b0;
    case (f3)
      3'b000: br_tk = Zero;
      3'b001: br_tk = !Zero;
      3'b100: br_tk = Neg ^ Ovf;
      3'b101: br_tk = !(Neg ^ Ovf);
      3'b110: br_tk = !Carry;
      3'b111: br_tk = Carry;
      default: br_ok = 1'b0;
    endcase
  end

  always_comb begin
    disp = S_ILLEGAL;
    case (op)
      OP_LOAD,
      OP_STORE: disp = S_MEMADR;
      OP_R:     disp = S_EXECR;
      OP_I:     disp = S_EXECI;
      OP_BR:    disp = S_BRANCH;
      OP_JAL:   disp = S_JAL;
      OP_JALR:  disp = S_JALR;
`ifdef RV_UPPER_EN
      OP_LUI,
      OP_AUIPC: disp = S_UPPER;
`endif
      default:  disp = S_ILLEGAL;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pcw         = 1'b0;
    irw         = 1'b0;
    rw          = 1'b0;
    mw          = 1'b0;
    ill_raw     = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALU_Control = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_done) begin
          irw     = 1'b1;
          pcw     = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        state_d = disp;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = Instr[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_done) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw        = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mw     = 1'b1;
        if (mem_done) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA     = 2'b10;
        ALU_Control = alu_dec;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA     = 2'b10;
        ALUSrcB     = 2'b01;
        ALU_Control = alu_dec;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        rw      = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 2'b10;
        ALU_Control = ALU_SUB;
        if (br_ok) begin
          pcw     = br_tk;
          state_d = S_FETCH;
        end else begin
          state_d = S_ILLEGAL;
        end
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pcw     = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcw       = 1'b1;
        state_d   = S_LINK;
      end
      S_LINK: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        state_d = S_ALUWB;
      end
`ifdef RV_UPPER_EN
      S_UPPER: begin
        // LUI adds the immediate to zero, AUIPC to the old PC.
        ALUSrcA = Instr[5] ? 2'b11 : 2'b01;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
`endif
      S_ILLEGAL: begin
        ill_raw = 1'b1;
      end
      default: begin
        state_d = S_ILLEGAL;
      end
    endcase
  end

  // Only terminal states ever return to FETCH.
  assign done_raw = (state_q != S_FETCH) && (state_d == S_FETCH);

  // Counter reloads on every state change so each memory state starts fresh.
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = CW'(MEM_WAIT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= CW'(MEM_WAIT);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes are masked combinationally so they drop the moment rst rises.
  assign PCWrite    = pcw      & ~rst;
  assign IRWrite    = irw      & ~rst;
  assign RegWrite   = rw       & ~rst;
  assign MemWrite   = mw       & ~rst;
  assign instr_done = done_raw & ~rst;
  assign illegal    = ill_raw  & ~rst;

endmodule

// File: tb/tb_multicycle_controlpath.sv
// tb_multicycle_controlpath: randomized self-checking bench; expected
// per-cycle outputs are built from instruction class and memory timing.
module tb_multicycle_controlpath;

  localparam int MW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Instr;
  logic        Zero, Neg, Carry, Ovf;
  logic        mem_ready;
  logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALU_Control;
  logic        instr_done, illegal;

  int checks = 0;
  int failures = 0;

  // {pcw,irw,rw,mw,adr,rsrc[2],srca[2],srcb[2],imm[3],alu[4],done,ill}
  typedef logic [19:0] ov_t;
  ov_t        exp_q[$];
  ov_t        obs_q[$];
  bit         rdy_q[$];
  logic [2:0] cur_imm;
  bit         ends_ill;
  ov_t        obs;

  multicycle_controlpath #(.MEM_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .Instr(Instr),
    .Zero(Zero), .Neg(Neg), .Carry(Carry), .Ovf(Ovf),
    .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALU_Control(ALU_Control), .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc,
                ALUSrcA, ALUSrcB, ImmSrc, ALU_Control, instr_done, illegal};

  function automatic ov_t v(input bit pcw, irw, rw, mw, adr,
                            input logic [1:0] rs, sa, sb,
                            input logic [3:0] alu, input bit dn, il);
    return {pcw, irw, rw, mw, adr, rs, sa, sb, cur_imm, alu, dn, il};
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
`ifdef RV_UPPER_EN
      7'b0110111, 7'b0010111: return 3'b100;
`endif
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [31:0] ins, input bit rt);
    case (ins[14:12])
      3'd0: return (rt && ins[30]) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return ins[30] ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic bit br_taken(input logic [2:0] f, input logic [31:0] a, b);
    case (f)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) < $signed(b);
      3'b101: return $signed(a) >= $signed(b);
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_flags(input logic [31:0] a, b);
    logic [31:0] d;
    d = a - b;
    Zero  = (d == 32'd0);
    Neg   = d[31];
    Carry = (a >= b);
    Ovf   = (a[31] != b[31]) && (d[31] != a[31]);
  endtask

  task automatic one(input ov_t e);
    exp_q.push_back(e);
    rdy_q.push_back($urandom_range(0, 1) != 0);
  endtask

  // Memory access lasting max(MW, d)+1 cycles; ready may bounce early.
  task automatic mem_phase(input int kind, input int d);
    int n;
    bit last, r;
    n = (d > MW) ? d : MW;
    for (int k = 0; k <= n; k++) begin
      last = (k == n);
      if (k >= d) r = 1'b1;
      else if (k < MW) r = ($urandom_range(0, 1) != 0);
      else r = 1'b0;
      rdy_q.push_back(r);
      case (kind)
        0: exp_q.push_back(v(last, last, 0, 0, 0, 2'b10, 2'b00, 2'b10, 4'd0, 0, 0));
        1: exp_q.push_back(v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'd0, 0, 0));
        default: exp_q.push_back(v(0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 4'd0, last, 0));
      endcase
    end
  endtask

  task automatic ill_tail();
    repeat (4) one(v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0, 1));
    ends_ill = 1'b1;
  endtask

  task automatic build(input logic [31:0] ins, input int d, input bit tk);
    logic [6:0] op;
    ov_t wb, ma;
    op = ins[6:0];
    exp_q.delete();
    rdy_q.delete();
    ends_ill = 1'b0;
    cur_imm = imm_of(op);
    wb = v(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 1, 0);
    ma = v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd0, 0, 0);
    mem_phase(0, d);
    one(v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'd0, 0, 0));
    case (op)
      7'b0000011: begin
        one(ma);
        mem_phase(1, d);
        one(v(0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b00, 4'd0, 1, 0));
      end
      7'b0100011: begin
        one(ma);
        mem_phase(2, d);
      end
      7'b0110011: begin
        one(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu_of(ins, 1), 0, 0));
        one(wb);
      end
      7'b0010011: begin
        one(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu_of(ins, 0), 0, 0));
        one(wb);
      end
      7'b1100011: begin
        if (ins[14:13] == 2'b01) begin
          one(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'd1, 0, 0));
          ill_tail();
        end else begin
          one(v(tk, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'd1, 1, 0));
        end
      end
      7'b1101111: begin
        one(v(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 4'd0, 0, 0));
        one(wb);
      end
      7'b1100111: begin
        one(v(1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 4'd0, 0, 0));
        one(v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 4'd0, 0, 0));
        one(wb);
      end
`ifdef RV_UPPER_EN
      7'b0110111, 7'b0010111: begin
        one(v(0, 0, 0, 0, 0, 2'b00, op[5] ? 2'b11 : 2'b01, 2'b01, 4'd0, 0, 0));
        one(wb);
      end
`endif
      default: ill_tail();
    endcase
  endtask

  // Starts and ends on a falling edge; samples 1 ns after driving.
  task automatic run_seq(input logic [31:0] ins, input logic [31:0] a, b);
    Instr = ins;
    set_flags(a, b);
    obs_q.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_ready = rdy_q[i];
      #1;
      obs_q.push_back(obs);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    Instr = 32'h003100B3;
    mem_ready = 1'b1;
    set_flags(0, 0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({PCWrite, IRWrite, RegWrite, MemWrite, instr_done, illegal} !== 6'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=000000",
               {PCWrite, IRWrite, RegWrite, MemWrite, instr_done, illegal});
    end
    checks++;
    if ({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc} !== 7'b0_00_10_10) begin
      failures++;
      $display("FAIL reset_fetch_sel got=%b exp=0001010",
               {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    int n;
    build(32'h003100B3, 0, 1'b0);
    run_seq(32'h003100B3, 0, 0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL add cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    n = 0;
    foreach (obs_q[i]) if (obs_q[i][1]) n++;
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL add_done_count got=%0d exp=1", n);
    end
  endtask

  task automatic test_load_wait();
    int na, nr;
    build(32'h0002A303, 4, 1'b0);
    run_seq(32'h0002A303, 0, 0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL load cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    na = 0;
    nr = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i][15]) na++;
      if (obs_q[i][17]) nr++;
    end
    checks++;
    if (na != 5 || nr != 1 || obs_q[obs_q.size()-1][14:13] !== 2'b01) begin
      failures++;
      $display("FAIL load_shape memread=%0d exp=5 regwrites=%0d exp=1", na, nr);
    end
  endtask

  task automatic test_branches();
    logic [2:0] fs [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [31:0] ins, a, b;
    bit tk;
    foreach (fs[j]) begin
      for (int t = 0; t < 4; t++) begin
        a = $urandom_range(1, 1000);
        case (t)
          0: b = a;
          1: b = a + 32'd1;
          2: b = a - 32'd1;
          default: begin
            a = 32'h8000_0000 | $urandom;
            b = $urandom_range(0, 1000);
          end
        endcase
        ins = $urandom;
        ins[6:0] = 7'b1100011;
        ins[14:12] = fs[j];
        tk = br_taken(fs[j], a, b);
        build(ins, $urandom_range(0, 3), tk);
        run_seq(ins, a, b);
        foreach (exp_q[i]) begin
          checks++;
          if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL branch f3=%0d a=%h b=%h cyc=%0d got=%h exp=%h",
                     fs[j], a, b, i, obs_q[i], exp_q[i]);
          end
        end
      end
    end
  endtask

  task automatic test_branch_illegal();
    logic [31:0] ins;
    for (int k = 0; k < 2; k++) begin
      ins = $urandom;
      ins[6:0] = 7'b1100011;
      ins[14:12] = (k == 0) ? 3'b010 : 3'b011;
      build(ins, 1, 1'b1);
      run_seq(ins, 5, 5);
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL br_illegal k=%0d cyc=%0d got=%h exp=%h",
                   k, i, obs_q[i], exp_q[i]);
        end
      end
      rst = 1'b1;
      #1;
      checks++;
      if (illegal !== 1'b0) begin
        failures++;
        $display("FAIL illegal_in_reset got=%b exp=0", illegal);
      end
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  task automatic test_jalr();
    build(32'h000080E7, 0, 1'b0);
    run_seq(32'h000080E7, 0, 0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL jalr cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_store();
    int n;
    bit seen;
    Instr = 32'h0062A023;
    set_flags(0, 0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      mem_ready = 1'b1;
      #1;
      if (MemWrite === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    mem_ready = 1'b0;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL store_reach timeout got=%0d cycles exp=memwrite", n);
    end
    @(posedge clk);
    #2;
    checks++;
    if (MemWrite !== 1'b1) begin
      failures++;
      $display("FAIL store_hold got=%b exp=1", MemWrite);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({PCWrite, IRWrite, RegWrite, MemWrite, instr_done, illegal} !== 6'b0) begin
      failures++;
      $display("FAIL store_async_drop got=%b exp=000000",
               {PCWrite, IRWrite, RegWrite, MemWrite, instr_done, illegal});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (IRWrite !== 1'b0 || ALUSrcB !== 2'b10 || MemWrite !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_fetch c=%0d irw=%b srcb=%b mw=%b exp=0/10/0",
                 c, IRWrite, ALUSrcB, MemWrite);
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_ready irw=%b pcw=%b exp=1/1", IRWrite, PCWrite);
    end
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_upper();
    logic [31:0] ins [2];
    ins[0] = 32'h123450B7;
    ins[1] = {$urandom_range(0, 32'hFFFFF), 5'd3, 7'b0010111};
    for (int k = 0; k < 2; k++) begin
      build(ins[k], $urandom_range(0, 3), 1'b0);
      run_seq(ins[k], 0, 0);
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL upper k=%0d cyc=%0d got=%h exp=%h",
                   k, i, obs_q[i], exp_q[i]);
        end
      end
      if (ends_ill) do_reset();
    end
  endtask

  task automatic test_random();
    logic [31:0] ins, a, b;
    logic [2:0] f;
    bit tk;
    for (int n = 0; n < 40; n++) begin
      ins = $urandom;
      case ($urandom_range(0, 9))
        0: ins[6:0] = 7'b0000011;
        1: ins[6:0] = 7'b0100011;
        2: ins[6:0] = 7'b0110011;
        3: ins[6:0] = 7'b0010011;
        4: ins[6:0] = 7'b1100011;
        5: ins[6:0] = 7'b1101111;
        6: ins[6:0] = 7'b1100111;
        7: ins[6:0] = 7'b0110111;
        8: ins[6:0] = 7'b0010111;
        default: ins[6:0] = 7'b0001111;
      endcase
      if (ins[6:0] == 7'b1100011) begin
        f = 3'($urandom_range(0, 5));
        if (f > 3'd1) f = f + 3'd2;
        ins[14:12] = f;
      end
      a = $urandom;
      b = ($urandom_range(0, 1) != 0) ? a : $urandom;
      tk = br_taken(ins[14:12], a, b);
      build(ins, $urandom_range(0, 4), tk);
      run_seq(ins, a, b);
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL random n=%0d ins=%h cyc=%0d got=%h exp=%h",
                   n, ins, i, obs_q[i], exp_q[i]);
        end
      end
      if (ends_ill) do_reset();
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0;
    Instr = 32'h0;
    Zero = 1'b0;
    Neg = 1'b0;
    Carry = 1'b0;
    Ovf = 1'b0;
    test_reset();
    test_add();
    test_load_wait();
    test_branches();
    test_branch_illegal();
    test_jalr();
    test_reset_mid_store();
    test_upper();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
